// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants, control bundle and helpers
package vga_timing_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int VGA640_H_ACT  = 640;
  localparam int VGA640_H_FP   = 16;
  localparam int VGA640_H_SYNC = 96;
  localparam int VGA640_H_BP   = 48;
  localparam int VGA640_V_ACT  = 480;
  localparam int VGA640_V_FP   = 10;
  localparam int VGA640_V_SYNC = 2;
  localparam int VGA640_V_BP   = 33;

  // 800x600 @ 72 Hz, 50 MHz pixel clock
  localparam int SVGA800_H_ACT  = 800;
  localparam int SVGA800_H_FP   = 56;
  localparam int SVGA800_H_SYNC = 120;
  localparam int SVGA800_H_BP   = 64;
  localparam int SVGA800_V_ACT  = 600;
  localparam int SVGA800_V_FP   = 37;
  localparam int SVGA800_V_SYNC = 6;
  localparam int SVGA800_V_BP   = 23;

  // Per-position control bits carried down the alignment pipeline
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic fetch;
  } vga_ctl_t;

  // Blanking interval length: front porch + sync + back porch
  function automatic int blank_len(input int fp, input int sync, input int bp);
    return fp + sync + bp;
  endfunction

  // Full line or frame length including the active region
  function automatic int total_len(input int fp, input int sync, input int bp, input int act);
    return fp + sync + bp + act;
  endfunction

  // Pin level for a sync output given its asserted polarity
  function automatic logic sync_level(input logic pol, input logic asserted);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_param_delay.sv
// rtl/vga_timing_gen_param_delay.sv - parametrised shift register with synchronous clear
module vga_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    // Zero depth is a plain wire; clock and clear are intentionally ignored
    logic unused_ok;
    assign unused_ok = &{1'b0, clk_i, clr_i};
    assign q_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per clock; clear empties every stage at once
    always_ff @(posedge clk_i) begin
      if (clr_i) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen_param.sv
// rtl/vga_timing_gen_param.sv - parametrised VGA timing generator with frame-buffer fetch
module vga_timing_gen_param
  import vga_timing_pkg::*;
#(
  parameter int   H_ACT   = VGA640_H_ACT,
  parameter int   H_FP    = VGA640_H_FP,
  parameter int   H_SYNC  = VGA640_H_SYNC,
  parameter int   H_BP    = VGA640_H_BP,
  parameter int   V_ACT   = VGA640_V_ACT,
  parameter int   V_FP    = VGA640_V_FP,
  parameter int   V_SYNC  = VGA640_V_SYNC,
  parameter int   V_BP    = VGA640_V_BP,
  parameter int   V_MARK  = 0,
  parameter int   COLOR_W = 8,
  parameter int   RD_LAT  = 2,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0,
  parameter int   CNT_W   = 12
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iEN,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic               READ_Request,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oVGA_CLOCK,
  output logic               oFrame_Start,
  output logic [CNT_W-1:0]   oH_Cont,
  output logic [CNT_W-1:0]   oV_Cont
);

  localparam int H_BLANK = blank_len(H_FP, H_SYNC, H_BP);
  localparam int H_TOTAL = total_len(H_FP, H_SYNC, H_BP, H_ACT);
  localparam int V_BLANK = blank_len(V_FP, V_SYNC, V_BP);
  localparam int V_TOTAL = total_len(V_FP, V_SYNC, V_BP, V_ACT);
  // One stage matches the READ_Request register, RD_LAT more cover the memory latency
  localparam int DLY     = RD_LAT + 1;

  logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
  logic               clr;
  vga_ctl_t           ctl0, ctl_al;
  logic               fs0;
  logic               req_q, fs_q, blank_q, hs_q, vs_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  // Disable behaves like reset so a re-enable always restarts at (0,0)
  assign clr = !iRST_N || !iEN;

  // Next counter position: H wraps at end of line, V advances on each H wrap
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == CNT_W'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
    end
  end

  // Frame position counters
  always_ff @(posedge iCLK) begin
    if (clr) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Stage-0 decode of the current position
  always_comb begin
    ctl0.hs    = (h_q >= CNT_W'(H_FP)) && (h_q < CNT_W'(H_FP + H_SYNC));
    ctl0.vs    = (v_q >= CNT_W'(V_FP)) && (v_q < CNT_W'(V_FP + V_SYNC));
    ctl0.act   = (h_q >= CNT_W'(H_BLANK)) && (v_q >= CNT_W'(V_BLANK));
    ctl0.fetch = ctl0.act && (v_q >= CNT_W'(V_BLANK + V_MARK));
    fs0        = (h_q == CNT_W'(H_BLANK)) && (v_q == CNT_W'(V_BLANK + V_MARK));
  end

  vga_delay_line #(
    .DEPTH (DLY),
    .WIDTH ($bits(vga_ctl_t))
  ) u_align (
    .clk_i (iCLK),
    .clr_i (clr),
    .d_i   (ctl0),
    .q_o   (ctl_al)
  );

  // Request/frame-start registered from stage 0; pixel outputs from the aligned stage
  always_ff @(posedge iCLK) begin
    if (clr) begin
      req_q   <= 1'b0;
      fs_q    <= 1'b0;
      blank_q <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      req_q   <= ctl0.fetch;
      fs_q    <= fs0;
      blank_q <= ctl_al.act;
      hs_q    <= sync_level(HS_POL, ctl_al.hs);
      vs_q    <= sync_level(VS_POL, ctl_al.vs);
      r_q     <= ctl_al.fetch ? iRed   : '0;
      g_q     <= ctl_al.fetch ? iGreen : '0;
      b_q     <= ctl_al.fetch ? iBlue  : '0;
    end
  end

  assign READ_Request = req_q;
  assign oFrame_Start = fs_q;
  assign oVGA_BLANK   = blank_q;
  assign oVGA_H_SYNC  = hs_q;
  assign oVGA_V_SYNC  = vs_q;
  assign oVGA_R       = r_q;
  assign oVGA_G       = g_q;
  assign oVGA_B       = b_q;
  assign oVGA_SYNC    = 1'b0;
  assign oVGA_CLOCK   = iCLK;
  assign oH_Cont      = h_q;
  assign oV_Cont      = v_q;

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// tb/tb_vga_timing_gen_param.sv - self-checking bench for vga_timing_gen_param
module tb_vga_timing_gen_param;

  // Reduced timing so whole frames fit in a short run
  localparam int HFP = 2, HSW = 3, HBP = 4, HACT = 16;
  localparam int VFP = 1, VSW = 2, VBP = 3, VACT = 12;
  localparam int HB = HFP + HSW + HBP, HT = HB + HACT;
  localparam int VB = VFP + VSW + VBP, VT = VB + VACT;
  localparam int FRAME = HT * VT;
  localparam int NI = 4;
  localparam int   LAT  [NI] = '{2, 0, 7, 3};
  localparam int   VM   [NI] = '{0, 0, 0, 9};
  localparam logic HPOL [NI] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic VPOL [NI] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic [7:0] red = 8'h0, green = 8'h0, blue = 8'h0;

  logic [NI-1:0] req, fs, blank, hs, vs, syn, vclk;
  logic [7:0]  vr [NI];
  logic [7:0]  vg [NI];
  logic [7:0]  vb [NI];
  logic [11:0] hc [NI];
  logic [11:0] vc [NI];
  logic [53:0] obs [NI];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    vga_timing_gen_param #(
      .H_ACT(HACT), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACT(VACT), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .V_MARK(VM[gi]), .COLOR_W(8), .RD_LAT(LAT[gi]),
      .HS_POL(HPOL[gi]), .VS_POL(VPOL[gi]), .CNT_W(12)
    ) u_dut (
      .iCLK(clk), .iRST_N(rst_n), .iEN(en),
      .iRed(red), .iGreen(green), .iBlue(blue),
      .READ_Request(req[gi]),
      .oVGA_R(vr[gi]), .oVGA_G(vg[gi]), .oVGA_B(vb[gi]),
      .oVGA_H_SYNC(hs[gi]), .oVGA_V_SYNC(vs[gi]),
      .oVGA_BLANK(blank[gi]), .oVGA_SYNC(syn[gi]), .oVGA_CLOCK(vclk[gi]),
      .oFrame_Start(fs[gi]), .oH_Cont(hc[gi]), .oV_Cont(vc[gi])
    );
    assign obs[gi] = {req[gi], fs[gi], blank[gi], hs[gi], vs[gi], syn[gi],
                      vr[gi], vg[gi], vb[gi], hc[gi], vc[gi]};
  end

  // Reference model state: clocks since the last clear, and the pixel data seen at each edge
  int tclr = 0;
  logic [7:0] lr = 8'h0, lg = 8'h0, lb = 8'h0;
  always @(posedge clk) begin
    if (!rst_n || !en) tclr <= 0;
    else tclr <= tclr + 1;
    lr <= red;
    lg <= green;
    lb <= blue;
  end

  // Screen-position properties {hs, vs, act, fetch} of frame position p
  function automatic logic [3:0] dec(input int p, input int vm);
    int h, v;
    h = (p % FRAME) % HT;
    v = (p % FRAME) / HT;
    return {(h >= HFP && h < HFP + HSW), (v >= VFP && v < VFP + VSW),
            (h >= HB && v >= VB), (h >= HB && v >= VB + vm)};
  endfunction

  // Expected output vector of instance i, derived from elapsed time since clear
  function automatic logic [53:0] exp_out(input int i);
    int t, p;
    logic [3:0] d, d0;
    logic rq, f;
    logic [7:0] er, eg, eb;
    t = tclr;
    rq = 1'b0;
    f = 1'b0;
    if (t >= 1) begin
      d0 = dec(t - 1, VM[i]);
      rq = d0[0];
      f = (((t - 1) % FRAME) == (VB + VM[i]) * HT + HB);
    end
    d = 4'b0;
    if (t >= LAT[i] + 2) d = dec(t - LAT[i] - 2, VM[i]);
    er = d[0] ? lr : 8'h0;
    eg = d[0] ? lg : 8'h0;
    eb = d[0] ? lb : 8'h0;
    p = t % FRAME;
    return {rq, f, d[1], (d[3] ? HPOL[i] : ~HPOL[i]), (d[2] ? VPOL[i] : ~VPOL[i]), 1'b0,
            er, eg, eb, 12'(p % HT), 12'(p / HT)};
  endfunction

  // Advance one clock with fresh random pixel data; sample point is 1 ns after the edge
  task automatic tick();
    red = 8'($urandom);
    green = 8'($urandom);
    blue = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs[i] !== exp_out(i)) begin
          failures++;
          $display("FAIL reset_state inst%0d got=%h exp=%h", i, obs[i], exp_out(i));
        end
        checks++;
        if (vclk[i] !== clk) begin
          failures++;
          $display("FAIL clock_passthru inst%0d got=%b exp=%b", i, vclk[i], clk);
        end
      end
    end
  endtask

  task automatic test_frames();
    int hrun[NI], hst[NI], vrun[NI], vst[NI], rrun[NI], rcnt[NI], fcnt[NI];
    logic hprev[NI], vprev[NI];
    logic ha, va;
    for (int i = 0; i < NI; i++) begin
      hrun[i] = 0; hst[i] = -1; vrun[i] = 0; vst[i] = -1;
      rrun[i] = 0; rcnt[i] = 0; fcnt[i] = 0; hprev[i] = 1'b0; vprev[i] = 1'b0;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2 * FRAME + 20; c++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs[i] !== exp_out(i)) begin
          failures++;
          $display("FAIL frame_vector inst%0d t=%0d got=%h exp=%h", i, tclr, obs[i], exp_out(i));
        end
        ha = (hs[i] === HPOL[i]);
        if (ha) begin
          if (!hprev[i]) begin
            if (hst[i] >= 0) begin
              checks++;
              if (c - hst[i] != HT) begin
                failures++;
                $display("FAIL hsync_period inst%0d got=%0d exp=%0d", i, c - hst[i], HT);
              end
            end
            hst[i] = c;
          end
          hrun[i]++;
        end else if (hprev[i]) begin
          checks++;
          if (hrun[i] != HSW) begin
            failures++;
            $display("FAIL hsync_width inst%0d got=%0d exp=%0d", i, hrun[i], HSW);
          end
          hrun[i] = 0;
        end
        hprev[i] = ha;
        va = (vs[i] === VPOL[i]);
        if (va) begin
          if (!vprev[i]) begin
            if (vst[i] >= 0) begin
              checks++;
              if (c - vst[i] != FRAME) begin
                failures++;
                $display("FAIL vsync_period inst%0d got=%0d exp=%0d", i, c - vst[i], FRAME);
              end
            end
            vst[i] = c;
          end
          vrun[i]++;
        end else if (vprev[i]) begin
          checks++;
          if (vrun[i] != VSW * HT) begin
            failures++;
            $display("FAIL vsync_width inst%0d got=%0d exp=%0d", i, vrun[i], VSW * HT);
          end
          vrun[i] = 0;
        end
        vprev[i] = va;
        if (req[i]) rrun[i]++;
        else if (rrun[i] > 0) begin
          checks++;
          if (rrun[i] != HACT) begin
            failures++;
            $display("FAIL request_run inst%0d got=%0d exp=%0d", i, rrun[i], HACT);
          end
          rrun[i] = 0;
        end
        if (c < FRAME) begin
          rcnt[i] += int'(req[i]);
          fcnt[i] += int'(fs[i]);
        end
        if (c == FRAME - 1) begin
          checks++;
          if (rcnt[i] != HACT * (VACT - VM[i])) begin
            failures++;
            $display("FAIL requests_per_frame inst%0d got=%0d exp=%0d", i, rcnt[i], HACT * (VACT - VM[i]));
          end
          checks++;
          if (fcnt[i] != 1) begin
            failures++;
            $display("FAIL frame_start_count inst%0d got=%0d exp=1", i, fcnt[i]);
          end
        end
      end
    end
  endtask

  task automatic test_vmark();
    int fcnt, bcnt;
    fcnt = 0;
    bcnt = 0;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs[i] !== exp_out(i)) begin
          failures++;
          $display("FAIL vmark_vector inst%0d t=%0d got=%h exp=%h", i, tclr, obs[i], exp_out(i));
        end
      end
      bcnt += int'(blank[3]);
      if (fs[3]) begin
        fcnt++;
        checks++;
        if (req[3] !== 1'b1 || vc[3] != 12'(VB + 9) || hc[3] != 12'(HB + 1)) begin
          failures++;
          $display("FAIL vmark_first_request got req=%b h=%0d v=%0d exp req=1 h=%0d v=%0d",
                   req[3], hc[3], vc[3], HB + 1, VB + 9);
        end
      end
    end
    checks++;
    if (fcnt != 1) begin
      failures++;
      $display("FAIL vmark_frame_start_count got=%0d exp=1", fcnt);
    end
    checks++;
    if (bcnt != HACT * VACT) begin
      failures++;
      $display("FAIL vmark_blank_cycles got=%0d exp=%0d", bcnt, HACT * VACT);
    end
  endtask

  task automatic test_mid_reset();
    int k;
    bit found;
    found = 0;
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      if (hc[0] == 12'd20 && vc[0] == 12'd8) found = 1;
      else tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mid_reset_position got h=%0d v=%0d exp h=20 v=8", hc[0], vc[0]);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (req[i] !== 1'b0 || blank[i] !== 1'b0 || hs[i] !== ~HPOL[i] || vs[i] !== ~VPOL[i]) begin
        failures++;
        $display("FAIL mid_reset_outputs inst%0d got req=%b blank=%b hs=%b vs=%b", i, req[i], blank[i], hs[i], vs[i]);
      end
    end
    k = 0;
    found = 0;
    while (!found && k < 2 * FRAME) begin
      tick();
      k++;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs[i] !== exp_out(i)) begin
          failures++;
          $display("FAIL restart_vector inst%0d t=%0d got=%h exp=%h", i, tclr, obs[i], exp_out(i));
        end
      end
      if (req[0]) found = 1;
    end
    checks++;
    if (k != HB + VB * HT + 1) begin
      failures++;
      $display("FAIL restart_latency got=%0d exp=%0d", k, HB + VB * HT + 1);
    end
  endtask

  task automatic test_enable();
    int rcnt;
    repeat ($urandom_range(300, 50)) tick();
    en = 1'b0;
    repeat ($urandom_range(20, 1)) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (hc[i] !== 12'd0 || vc[i] !== 12'd0 || req[i] !== 1'b0 || blank[i] !== 1'b0) begin
          failures++;
          $display("FAIL enable_low inst%0d got h=%0d v=%0d req=%b blank=%b", i, hc[i], vc[i], req[i], blank[i]);
        end
      end
    end
    en = 1'b1;
    rcnt = 0;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      rcnt += int'(req[0]);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs[i] !== exp_out(i)) begin
          failures++;
          $display("FAIL enable_vector inst%0d t=%0d got=%h exp=%h", i, tclr, obs[i], exp_out(i));
        end
      end
    end
    checks++;
    if (rcnt != HACT * VACT) begin
      failures++;
      $display("FAIL enable_requests got=%0d exp=%0d", rcnt, HACT * VACT);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      rst_n = ($urandom_range(199, 0) != 0);
      en = ($urandom_range(99, 0) != 0);
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs[i] !== exp_out(i)) begin
          failures++;
          $display("FAIL random_vector inst%0d t=%0d got=%h exp=%h", i, tclr, obs[i], exp_out(i));
        end
      end
    end
    rst_n = 1'b1;
    en = 1'b1;
  endtask

  initial begin
    #1;
    test_reset();
    test_frames();
    test_vmark();
    test_mid_reset();
    test_enable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
